// File: rtl/rot_tl_guard.sv
// Single-outstanding TL-UL guard in front of the RoT: screens address/opcode, bounds device latency.
// Latency: +1 cycle on A and on D; backpressure: holds host A until the previous response (or drained late beat) retires.
module rot_tl_guard #(
  parameter int unsigned TimeoutCycles = 1024,
  parameter logic [31:0] BaseAddr      = 32'h3B00_0000,
  parameter logic [31:0] AddrSize      = 32'h0010_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        host_a_valid,
  output logic        host_a_ready,
  input  logic [2:0]  host_a_bits_opcode,
  input  logic [2:0]  host_a_bits_param,
  input  logic [1:0]  host_a_bits_size,
  input  logic [7:0]  host_a_bits_source,
  input  logic [31:0] host_a_bits_address,
  input  logic [3:0]  host_a_bits_mask,
  input  logic [31:0] host_a_bits_data,

  output logic        host_d_valid,
  input  logic        host_d_ready,
  output logic [2:0]  host_d_bits_opcode,
  output logic [2:0]  host_d_bits_param,
  output logic [1:0]  host_d_bits_size,
  output logic [7:0]  host_d_bits_source,
  output logic        host_d_bits_sink,
  output logic [31:0] host_d_bits_data,
  output logic        host_d_bits_denied,

  output logic        dev_a_valid,
  input  logic        dev_a_ready,
  output logic [2:0]  dev_a_bits_opcode,
  output logic [2:0]  dev_a_bits_param,
  output logic [1:0]  dev_a_bits_size,
  output logic [7:0]  dev_a_bits_source,
  output logic [31:0] dev_a_bits_address,
  output logic [3:0]  dev_a_bits_mask,
  output logic [31:0] dev_a_bits_data,

  input  logic        dev_d_valid,
  output logic        dev_d_ready,
  input  logic [2:0]  dev_d_bits_opcode,
  input  logic [2:0]  dev_d_bits_param,
  input  logic [1:0]  dev_d_bits_size,
  input  logic [7:0]  dev_d_bits_source,
  input  logic        dev_d_bits_sink,
  input  logic [31:0] dev_d_bits_data,
  input  logic        dev_d_bits_denied,

  output logic        busy_o,
  output logic [15:0] timeout_cnt_o
);

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [1:0]  size;
    logic [7:0]  source;
    logic [31:0] address;
    logic [3:0]  mask;
    logic [31:0] data;
  } a_hdr_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [1:0]  size;
    logic [7:0]  source;
    logic        sink;
    logic [31:0] data;
    logic        denied;
  } d_hdr_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  // 33-bit window bounds so a window ending at 4 GiB does not wrap.
  localparam logic [32:0] AddrLo    = {1'b0, BaseAddr};
  localparam logic [32:0] AddrHi    = {1'b0, BaseAddr} + {1'b0, AddrSize};
  localparam logic [15:0] TimerLast = 16'(TimeoutCycles - 1);

  state_e      state_q, state_d;
  a_hdr_t      req_q;
  d_hdr_t      rsp_q;
  logic [15:0] timer_q;
  logic [15:0] tmo_cnt_q;
  logic        stale_q;

  a_hdr_t      a_in;
  d_hdr_t      d_in;
  logic        a_op_ok;
  logic        a_addr_ok;
  logic        a_legal;
  logic        timer_hit;

  function automatic d_hdr_t err_rsp(input logic [2:0] op,
                                     input logic [1:0] size,
                                     input logic [7:0] source);
    d_hdr_t r;
    r        = '0;
    r.opcode = (op == 3'd4) ? 3'd1 : 3'd0;
    r.size   = size;
    r.source = source;
    r.data   = 32'hFFFF_FFFF;
    r.denied = 1'b1;
    return r;
  endfunction

  assign a_in = '{opcode:  host_a_bits_opcode,
                  param:   host_a_bits_param,
                  size:    host_a_bits_size,
                  source:  host_a_bits_source,
                  address: host_a_bits_address,
                  mask:    host_a_bits_mask,
                  data:    host_a_bits_data};

  assign d_in = '{opcode: dev_d_bits_opcode,
                  param:  dev_d_bits_param,
                  size:   dev_d_bits_size,
                  source: dev_d_bits_source,
                  sink:   dev_d_bits_sink,
                  data:   dev_d_bits_data,
                  denied: dev_d_bits_denied};

  assign a_op_ok   = (a_in.opcode == 3'd0) || (a_in.opcode == 3'd1) || (a_in.opcode == 3'd4);
  assign a_addr_ok = ({1'b0, a_in.address} >= AddrLo) && ({1'b0, a_in.address} < AddrHi);
  assign a_legal   = a_op_ok && a_addr_ok;
  assign timer_hit = (timer_q == TimerLast);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (host_a_valid) state_d = a_legal ? ST_REQ : ST_RESP;
      ST_REQ:   if (dev_a_ready) state_d = ST_WAIT;
      ST_WAIT:  if (dev_d_valid || timer_hit) state_d = ST_RESP;
      ST_RESP:  if (host_d_ready) state_d = stale_q ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (dev_d_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q     <= '0;
      rsp_q     <= '0;
      timer_q   <= '0;
      tmo_cnt_q <= '0;
      stale_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (host_a_valid) begin
            req_q <= a_in;
            if (!a_legal) rsp_q <= err_rsp(a_in.opcode, a_in.size, a_in.source);
          end
        end
        ST_REQ: begin
          if (dev_a_ready) timer_q <= '0;
        end
        ST_WAIT: begin
          timer_q <= timer_q + 16'd1;
          // A response arriving on the timeout cycle still wins.
          if (dev_d_valid) begin
            rsp_q <= d_in;
          end else if (timer_hit) begin
            rsp_q   <= err_rsp(req_q.opcode, req_q.size, req_q.source);
            stale_q <= 1'b1;
            if (tmo_cnt_q != 16'hFFFF) tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end
        ST_DRAIN: begin
          if (dev_d_valid) stale_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign host_a_ready = (state_q == ST_IDLE);
  assign dev_a_valid  = (state_q == ST_REQ);
  assign host_d_valid = (state_q == ST_RESP);
  assign dev_d_ready  = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
  assign busy_o       = (state_q != ST_IDLE);
  assign timeout_cnt_o = tmo_cnt_q;

  assign dev_a_bits_opcode  = req_q.opcode;
  assign dev_a_bits_param   = req_q.param;
  assign dev_a_bits_size    = req_q.size;
  assign dev_a_bits_source  = req_q.source;
  assign dev_a_bits_address = req_q.address;
  assign dev_a_bits_mask    = req_q.mask;
  assign dev_a_bits_data    = req_q.data;

  assign host_d_bits_opcode = rsp_q.opcode;
  assign host_d_bits_param  = rsp_q.param;
  assign host_d_bits_size   = rsp_q.size;
  assign host_d_bits_source = rsp_q.source;
  assign host_d_bits_sink   = rsp_q.sink;
  assign host_d_bits_data   = rsp_q.data;
  assign host_d_bits_denied = rsp_q.denied;

endmodule
